// File: rtl/pipe_ctrl_pkg.sv
// Shared Y86-64 encodings and control-unit types for the pipeline controller.
package pipe_ctrl_pkg;

    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_RET_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic f_stall;
        logic d_stall;
        logic d_bubble;
        logic e_bubble;
        logic m_bubble;
        logic w_stall;
        logic set_cc;
    } ctrl_t;

    // Instructions whose result arrives from memory (valM) rather than the ALU.
    function automatic logic is_load(input logic [3:0] icode);
        return (icode == IMRMOVQ) || (icode == IPOPQ);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stage-field / control-strobe bundle between the datapath (master) and pipe_ctrl (slave).
interface pipe_ctrl_if;

    logic [3:0] D_icode;
    logic [3:0] d_srcA;
    logic [3:0] d_srcB;
    logic [3:0] E_icode;
    logic [3:0] E_dstM;
    logic       e_Cnd;
    logic [2:0] m_stat;
    logic [2:0] W_stat;

    logic F_stall;
    logic D_stall;
    logic D_bubble;
    logic E_bubble;
    logic M_bubble;
    logic W_stall;
    logic set_cc;
    logic halted;

    modport master (
        output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, m_stat, W_stat,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted
    );

    modport slave (
        input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, m_stat, W_stat,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted
    );

endinterface

// File: rtl/pipe_ctrl_hazard.sv
// Same-cycle hazard detection: load-use, branch mispredict and exception status terms.
module pipe_ctrl_hazard
    import pipe_ctrl_pkg::*;
(
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_dstM,
    input  logic       e_Cnd,
    input  logic [2:0] m_stat,
    input  logic [2:0] W_stat,
    output logic       load_use,
    output logic       mispred,
    output logic       exc_m,
    output logic       exc_w
);

    // RNONE never creates a dependency, even though unused sources also read RNONE.
    assign load_use = is_load(E_icode) && (E_dstM != RNONE) &&
                      ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign mispred  = (E_icode == IJXX) && !e_Cnd;
    assign exc_m    = (m_stat != SAOK);
    assign exc_w    = (W_stat != SAOK);

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: ret countdown FSM, hazard strobes, halt latch.
// Optional perf counters (stall/bubble/cycle) are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RET_BUBBLES = 3,
    parameter int CNT_W       = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  pif
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] cycle_cnt
`endif
);

    localparam int RCW = (RET_BUBBLES > 1) ? $clog2(RET_BUBBLES) : 1;

    logic load_use, mispred, exc_m, exc_w;
    logic ret_go;
    ctrl_state_t state;
    logic [RCW-1:0] ret_cnt;
    logic halted_q;
    ctrl_t ctrl;

    pipe_ctrl_hazard u_hazard (
        .d_srcA   (pif.d_srcA),
        .d_srcB   (pif.d_srcB),
        .E_icode  (pif.E_icode),
        .E_dstM   (pif.E_dstM),
        .e_Cnd    (pif.e_Cnd),
        .m_stat   (pif.m_stat),
        .W_stat   (pif.W_stat),
        .load_use (load_use),
        .mispred  (mispred),
        .exc_m    (exc_m),
        .exc_w    (exc_w)
    );

    // A ret on a mispredicted path is squashed; a ret waiting on a load re-evaluates next cycle.
    assign ret_go = (pif.D_icode == IRET) && !load_use && !mispred;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            ret_cnt  <= '0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (exc_w) begin
                        state    <= ST_HALTED;
                        halted_q <= 1'b1;
                    end else if (ret_go) begin
                        state   <= ST_RET_WAIT;
                        ret_cnt <= RCW'(RET_BUBBLES - 1);
                    end
                end
                ST_RET_WAIT: begin
                    if (exc_w) begin
                        state    <= ST_HALTED;
                        halted_q <= 1'b1;
                    end else if (ret_cnt == '0) begin
                        state <= ST_RUN;
                    end else begin
                        ret_cnt <= ret_cnt - 1'b1;
                    end
                end
                ST_HALTED: begin
                    state    <= ST_HALTED;
                    halted_q <= 1'b1;
                end
                default: begin
                    state   <= ST_RUN;
                    ret_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        ctrl = '0;
        if (rst) begin
            ctrl.d_bubble = 1'b1;
            ctrl.e_bubble = 1'b1;
            ctrl.m_bubble = 1'b1;
        end else begin
            case (state)
                ST_HALTED: begin
                    ctrl.f_stall  = 1'b1;
                    ctrl.d_stall  = 1'b1;
                    ctrl.e_bubble = 1'b1;
                    ctrl.m_bubble = 1'b1;
                    ctrl.w_stall  = 1'b1;
                end
                ST_RET_WAIT: begin
                    ctrl.f_stall  = 1'b1;
                    ctrl.d_bubble = 1'b1;
                    ctrl.e_bubble = load_use || mispred;
                    ctrl.m_bubble = exc_m || exc_w;
                    ctrl.w_stall  = exc_w;
                    ctrl.set_cc   = (pif.E_icode == IOPQ) && !exc_m && !exc_w;
                end
                default: begin
                    ctrl.f_stall  = load_use || (pif.D_icode == IRET);
                    ctrl.d_stall  = load_use;
                    ctrl.d_bubble = mispred || ((pif.D_icode == IRET) && !load_use);
                    ctrl.e_bubble = load_use || mispred;
                    ctrl.m_bubble = exc_m || exc_w;
                    ctrl.w_stall  = exc_w;
                    ctrl.set_cc   = (pif.E_icode == IOPQ) && !exc_m && !exc_w;
                end
            endcase
        end
    end

    assign pif.F_stall  = ctrl.f_stall;
    assign pif.D_stall  = ctrl.d_stall;
    assign pif.D_bubble = ctrl.d_bubble;
    assign pif.E_bubble = ctrl.e_bubble;
    assign pif.M_bubble = ctrl.m_bubble;
    assign pif.W_stall  = ctrl.w_stall;
    assign pif.set_cc   = ctrl.set_cc;
    assign pif.halted   = halted_q;

`ifdef PIPE_CTRL_PERF_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Counters freeze once halted so the values describe the run up to the fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            cycle_cnt  <= '0;
        end else if (state != ST_HALTED) begin
            cycle_cnt <= sat_inc(cycle_cnt);
            if (ctrl.f_stall)
                stall_cnt <= sat_inc(stall_cnt);
            if (ctrl.d_bubble || ctrl.e_bubble)
                bubble_cnt <= sat_inc(bubble_cnt);
        end
    end
`endif

endmodule
